// File: rtl/frame_tick_sequencer.sv
// Frame tick divider plus erase/update/draw phase sequencer with overrun tracking.
// Optional one-deep tick queue enabled by defining TICK_QUEUE_EN.
module frame_tick_sequencer #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       erase_done,
    input  logic       update_done,
    input  logic       draw_done,
    input  logic       overrun_clr,
    output logic       tick,
    output logic       erase_req,
    output logic       update_req,
    output logic       draw_req,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StErase,
        StUpdate,
        StDraw
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    state_e           r_state;
    logic             r_busy;
    logic             r_erase_req;
    logic             r_update_req;
    logic             r_draw_req;
    logic             r_overrun;
    logic [7:0]       r_frame_cnt;

    logic             w_wrap;
    state_e           w_state_d;
    logic             w_tick_busy;
    logic             w_set_ovr;
    logic             w_pending_avail;
    logic             w_frame_inc;
    logic             w_overrun_d;

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    assign w_wrap = enable && (r_cnt == LastCnt);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (!enable || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_tick_busy = r_tick && (r_state != StIdle);

`ifdef TICK_QUEUE_EN
    logic r_pending;
    logic w_queue_tick;
    logic w_pending_d;

    // First tick during a frame is parked; a second one is a genuine overrun.
    assign w_queue_tick    = w_tick_busy && !r_pending;
    assign w_set_ovr       = w_tick_busy && r_pending;
    assign w_pending_avail = r_pending || w_queue_tick;

    always_comb begin
        w_pending_d = r_pending || w_queue_tick;
        if ((r_state == StDraw) && draw_done) begin
            w_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
        end
    end
`else
    assign w_set_ovr       = w_tick_busy;
    assign w_pending_avail = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Phase FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state;
        w_frame_inc = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_tick) begin
                    w_state_d = StErase;
                end
            end
            StErase: begin
                if (erase_done) begin
                    w_state_d = StUpdate;
                end
            end
            StUpdate: begin
                if (update_done) begin
                    w_state_d = StDraw;
                end
            end
            StDraw: begin
                if (draw_done) begin
                    w_frame_inc = 1'b1;
                    w_state_d   = w_pending_avail ? StErase : StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_overrun_d = r_overrun;
        if (w_set_ovr) begin
            w_overrun_d = 1'b1;
        end else if (overrun_clr) begin
            w_overrun_d = 1'b0;
        end
    end

    // Requests and busy are registered from the next state so they change on the same edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_erase_req  <= 1'b0;
            r_update_req <= 1'b0;
            r_draw_req   <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_state      <= w_state_d;
            r_busy       <= (w_state_d != StIdle);
            r_erase_req  <= (w_state_d == StErase);
            r_update_req <= (w_state_d == StUpdate);
            r_draw_req   <= (w_state_d == StDraw);
            r_overrun    <= w_overrun_d;
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign tick       = r_tick;
    assign erase_req  = r_erase_req;
    assign update_req = r_update_req;
    assign draw_req   = r_draw_req;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: doc/frame_tick_sequencer.md
Name: frame_tick_sequencer

Overview:
Game-frame scheduler for the BrickBreaker datapath. It divides the 50 MHz board clock into a fixed frame tick. Each tick starts one frame made of three phases: erase old objects, update positions/collisions, draw new objects. Each phase is handed to its datapath unit with a req/done handshake; the block guarantees phases never overlap and flags frames that overrun their slot.

Parameters:
TICK_DIV, 833333, clock cycles per frame tick (60 Hz at 50 MHz); legal range 4..2^CNT_W.
CNT_W, 20, divider counter width; must hold TICK_DIV-1.

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous, active-low reset
enable  in  1  divider run enable; low holds divider at 0
erase_done  in  1  erase unit finished; sampled only while erase_req high
update_done  in  1  update unit finished; sampled only while update_req high
draw_done  in  1  draw unit finished; sampled only while draw_req high
overrun_clr  in  1  synchronous clear of overrun flag
tick  out  1  one-cycle frame tick pulse, registered
erase_req  out  1  level request to erase unit
update_req  out  1  level request to update unit
draw_req  out  1  level request to draw unit
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: tick arrived while a frame was in progress
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (resetn low, asynchronous, any time, mid-frame included):
  - divider=0, state=IDLE.
  - tick, all req, busy, overrun = 0; frame_cnt = 0.
  - Release is synchronous: first counting edge is the first rising edge with resetn high.
- Divider:
  - enable high: cnt increments each cycle; at cnt==TICK_DIV-1 it wraps to 0.
  - tick is registered high for exactly the cycle following the wrap edge.
  - Tick period is exactly TICK_DIV cycles.
  - enable low: cnt forced to 0 synchronously, no tick.
  - enable does not affect a frame already in progress; the frame runs to completion.
- FSM states: IDLE, ERASE, UPDATE, DRAW; one-hot or binary is implementer's choice.
  - IDLE: tick high -> ERASE; erase_req rises on that edge, i.e. 1 cycle tick-to-req latency.
  - ERASE: erase_done high at edge -> UPDATE; erase_req falls and update_req rises on the same edge.
  - UPDATE: update_done high -> DRAW; same handover rule.
  - DRAW: draw_done high -> IDLE; draw_req falls and frame_cnt increments on the same edge.
- Handshake rules:
  - At most one req is high in any cycle.
  - A req holds until its done is sampled.
  - done inputs are ignored when their req is low; stale or early done pulses have no effect.
  - done may be asserted in the first cycle the req is high; minimum phase length is 1 cycle, so a full frame takes at least 3 cycles from req rise.
- busy = (state != IDLE), registered alongside state.
- Overrun:
  - A tick arriving in any state other than IDLE is dropped and sets overrun.
  - A tick in the same cycle as the DRAW->IDLE edge counts as busy and is dropped.
  - overrun_clr clears the flag; if a set and overrun_clr coincide, set wins.
- frame_cnt: unsigned 8-bit, wraps modulo 256, never saturates.

Optional Feature:
TICK_QUEUE_EN
- Defined: a one-deep pending flag is added.
  - A tick while busy sets pending, not overrun.
  - A tick while pending is already set sets overrun.
  - On the DRAW->IDLE edge with pending set, the FSM goes directly to ERASE (erase_req high next cycle, busy stays high) and pending clears.
  - pending resets to 0.
- Undefined: every tick while busy is dropped and sets overrun, as in Behaviour.

Test Plan:
1. TICK_DIV=10, enable=1, done units respond after 2 cycles -> tick every 10 cycles; erase/update/draw req each high 2 cycles in order, never overlapping; frame_cnt 0->1->2 over 2 ticks; overrun=0.
2. done inputs pulsed while all req low, plus draw_done asserted during ERASE -> no state change; frame_cnt unchanged.
3. update_done withheld for 15 cycles with TICK_DIV=10 -> second tick dropped, overrun=1, busy stays 1. Then pulse overrun_clr together with a new overrun tick -> overrun stays 1.
4. Run 256 fast frames (done responds in 1 cycle, TICK_DIV=4) -> frame_cnt returns to 0; 3-cycle minimum frame observed.
5. resetn pulsed low during UPDATE -> all outputs 0 immediately, without waiting for a clock edge. After release, first tick occurs TICK_DIV cycles later.
6. TICK_QUEUE_EN defined, frame lasting 14 cycles with TICK_DIV=10 -> the late tick is queued; erase_req rises one cycle after draw_done; overrun=0. A frame lasting 25 cycles -> overrun=1.
